// File: rtl/id_scoreboard_stage_if.sv
// ID-stage bundle: decoded instruction in, writeback and pipeline control in,
// and the registered ID/EX outputs plus hazard status out.
interface id_scoreboard_stage_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int CTRL_W = 24
);
    localparam int AW = $clog2(NREGS);

    // decode side
    logic              valid_i;
    logic [31:0]       instr_i;
    logic [XLEN-1:1]   pc_i;
    logic [XLEN-1:0]   imm_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic              uses_rs1_i;
    logic              uses_rs2_i;
    logic              reg_wen_i;
    logic              is_load_i;
    logic              is_long_i;

    // writeback side
    logic              rd_en_i;
    logic [AW-1:0]     rd_label_i;
    logic [XLEN-1:0]   rd_data_i;
    logic              wb_long_i;

    // pipeline control
    logic              busywait_i;
    logic              flush_i;

    // ID/EX outputs and status
    logic              stall_o;
    logic              valid_o;
    logic [XLEN-1:1]   pc_o;
    logic [XLEN-1:0]   rs1_value_o;
    logic [XLEN-1:0]   rs2_value_o;
    logic [XLEN-1:0]   imm_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [AW-1:0]     rd_o;
    logic [AW-1:0]     rs1_o;
    logic [AW-1:0]     rs2_o;
    logic              reg_wen_o;
    logic              is_load_o;
    logic              is_long_o;
    logic [NREGS-1:0]  sb_busy_o;
    logic [15:0]       stall_cnt_o;

    modport master (
        output valid_i, instr_i, pc_i, imm_i, ctrl_i,
               uses_rs1_i, uses_rs2_i, reg_wen_i, is_load_i, is_long_i,
               rd_en_i, rd_label_i, rd_data_i, wb_long_i,
               busywait_i, flush_i,
        input  stall_o, valid_o, pc_o, rs1_value_o, rs2_value_o, imm_o, ctrl_o,
               rd_o, rs1_o, rs2_o, reg_wen_o, is_load_o, is_long_o,
               sb_busy_o, stall_cnt_o
    );

    modport slave (
        input  valid_i, instr_i, pc_i, imm_i, ctrl_i,
               uses_rs1_i, uses_rs2_i, reg_wen_i, is_load_i, is_long_i,
               rd_en_i, rd_label_i, rd_data_i, wb_long_i,
               busywait_i, flush_i,
        output stall_o, valid_o, pc_o, rs1_value_o, rs2_value_o, imm_o, ctrl_o,
               rd_o, rs1_o, rs2_o, reg_wen_o, is_load_o, is_long_o,
               sb_busy_o, stall_cnt_o
    );
endinterface

// File: rtl/id_scoreboard_stage.sv
// Decode-stage operand fetch with register file, long-latency scoreboard,
// load-use interlock and the ID/EX pipeline register.
module id_scoreboard_stage #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int CTRL_W = 24
) (
    input  logic           clk_i,
    input  logic           rst_i,
    id_scoreboard_stage_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]    rs1, rs2, rd;
    logic [XLEN-1:0]  rf [NREGS];
    logic [XLEN-1:0]  rs1_value, rs2_value;
    logic [NREGS-1:0] sb, sb_eff, sb_next, clr_vec, set_vec;
    logic             sb_hazard, lu_hazard, stall, accept;
    logic             unused_instr;

    assign rd  = bus.instr_i[7  +: AW];
    assign rs1 = bus.instr_i[15 +: AW];
    assign rs2 = bus.instr_i[20 +: AW];
    assign unused_instr = ^bus.instr_i;

    // Read ports: x0 hard-wired, writeback in the same cycle forwards through.
    always_comb begin
        rs1_value = rf[rs1];
        rs2_value = rf[rs2];
        if (bus.rd_en_i && bus.rd_label_i != '0 && bus.rd_label_i == rs1) rs1_value = bus.rd_data_i;
        if (bus.rd_en_i && bus.rd_label_i != '0 && bus.rd_label_i == rs2) rs2_value = bus.rd_data_i;
        if (rs1 == '0) rs1_value = '0;
        if (rs2 == '0) rs2_value = '0;
    end

    // A long op retiring this cycle no longer blocks decode.
    assign clr_vec = (bus.rd_en_i && bus.wb_long_i) ? (NREGS'(1) << bus.rd_label_i) : '0;
    assign sb_eff  = sb & ~clr_vec;

    assign sb_hazard = bus.valid_i &&
                       ((bus.uses_rs1_i && rs1 != '0 && sb_eff[rs1]) ||
                        (bus.uses_rs2_i && rs2 != '0 && sb_eff[rs2]) ||
                        (bus.reg_wen_i  && rd  != '0 && sb_eff[rd]));

    assign lu_hazard = bus.valid_o && bus.is_load_o && bus.reg_wen_o && bus.rd_o != '0 &&
                       ((bus.uses_rs1_i && rs1 == bus.rd_o) ||
                        (bus.uses_rs2_i && rs2 == bus.rd_o));

    assign stall       = (sb_hazard || lu_hazard) && !bus.flush_i;
    assign bus.stall_o = stall;
    assign accept      = bus.valid_i && !stall && !bus.busywait_i && !bus.flush_i;

    // Set wins over a same-edge clear of the same register; bit 0 never tracks.
    always_comb begin
        set_vec = '0;
        if (accept && bus.is_long_i && bus.reg_wen_i && rd != '0) set_vec = NREGS'(1) << rd;
        sb_next    = (sb & ~clr_vec) | set_vec;
        sb_next[0] = 1'b0;
    end

    // NOTE: the register file is reset element by element, so it must map to
    // flops rather than a RAM macro; drop the reset branch if a RAM is wanted.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (bus.rd_en_i && bus.rd_label_i != '0) begin
            rf[bus.rd_label_i] <= bus.rd_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) sb <= '0;
        else        sb <= sb_next;
    end
    assign bus.sb_busy_o = sb;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            bus.stall_cnt_o <= '0;
        else if (stall && !bus.busywait_i && bus.stall_cnt_o != 16'hFFFF)
            bus.stall_cnt_o <= bus.stall_cnt_o + 16'd1;
    end

    // ID/EX register: hold > flush bubble > stall bubble > capture.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus.valid_o     <= 1'b0;
            bus.pc_o        <= '0;
            bus.rs1_value_o <= '0;
            bus.rs2_value_o <= '0;
            bus.imm_o       <= '0;
            bus.ctrl_o      <= '0;
            bus.rd_o        <= '0;
            bus.rs1_o       <= '0;
            bus.rs2_o       <= '0;
            bus.reg_wen_o   <= 1'b0;
            bus.is_load_o   <= 1'b0;
            bus.is_long_o   <= 1'b0;
        end else if (bus.busywait_i) begin
            // memory hold: everything keeps its value
        end else if (bus.flush_i || stall) begin
            bus.valid_o   <= 1'b0;
            bus.ctrl_o    <= '0;
            bus.reg_wen_o <= 1'b0;
            bus.is_load_o <= 1'b0;
            bus.is_long_o <= 1'b0;
        end else begin
            bus.valid_o     <= bus.valid_i;
            bus.pc_o        <= bus.pc_i;
            bus.rs1_value_o <= rs1_value;
            bus.rs2_value_o <= rs2_value;
            bus.imm_o       <= bus.imm_i;
            bus.ctrl_o      <= bus.ctrl_i;
            bus.rd_o        <= rd;
            bus.rs1_o       <= rs1;
            bus.rs2_o       <= rs2;
            bus.reg_wen_o   <= bus.reg_wen_i;
            bus.is_load_o   <= bus.is_load_i;
            bus.is_long_o   <= bus.is_long_i;
        end
    end
endmodule

// File: tb/tb_id_scoreboard_stage.sv
// Directed bench for id_scoreboard_stage: forwarding, x0, load-use, long-op
// scoreboard, busywait hold, flush, stall counter saturation and async reset.
module tb_id_scoreboard_stage;
    localparam int XLEN = 32, NREGS = 32, CTRL_W = 24;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    id_scoreboard_stage_if #(.XLEN(XLEN), .NREGS(NREGS), .CTRL_W(CTRL_W)) bus ();

    id_scoreboard_stage #(.XLEN(XLEN), .NREGS(NREGS), .CTRL_W(CTRL_W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
        mk = {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
    endfunction

    task automatic set_instr(input int rd, input int rs1, input int rs2,
                             input logic u1, input logic u2, input logic wen,
                             input logic ld, input logic lng);
        bus.valid_i    = 1'b1;
        bus.instr_i    = mk(rd, rs1, rs2);
        bus.uses_rs1_i = u1;
        bus.uses_rs2_i = u2;
        bus.reg_wen_i  = wen;
        bus.is_load_i  = ld;
        bus.is_long_i  = lng;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.valid_i = 0; bus.instr_i = '0; bus.pc_i = '0; bus.imm_i = '0; bus.ctrl_i = '0;
        bus.uses_rs1_i = 0; bus.uses_rs2_i = 0; bus.reg_wen_i = 0; bus.is_load_i = 0;
        bus.is_long_i = 0; bus.rd_en_i = 0; bus.rd_label_i = '0; bus.rd_data_i = '0;
        bus.wb_long_i = 0; bus.busywait_i = 0; bus.flush_i = 0;
        #1;
        check("rst_valid", 64'(bus.valid_o), 64'd0);
        check("rst_sb", 64'(bus.sb_busy_o), 64'd0);
        check("rst_cnt", 64'(bus.stall_cnt_o), 64'd0);
        check("rst_stall", 64'(bus.stall_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // writeback of x5 forwards into the rs1 read of the same cycle
        set_instr(1, 5, 0, 1, 0, 1, 0, 0);
        bus.pc_i = 31'h0000_0800; bus.imm_i = 32'h0000_0044; bus.ctrl_i = 24'hABCDE;
        bus.rd_en_i = 1; bus.rd_label_i = 5'd5; bus.rd_data_i = 32'hDEADBEEF;
        #1 check("fwd_stall", 64'(bus.stall_o), 64'd0);
        step();
        check("fwd_rs1", 64'(bus.rs1_value_o), 64'hDEADBEEF);
        check("fwd_valid", 64'(bus.valid_o), 64'd1);
        check("fwd_rd", 64'(bus.rd_o), 64'd1);
        check("fwd_ctrl", 64'(bus.ctrl_o), 64'hABCDE);
        check("fwd_imm", 64'(bus.imm_o), 64'h44);
        check("fwd_pc", 64'(bus.pc_o), 64'h800);

        // write to x0 is dropped; x0 reads 0, x5 now comes from the file
        set_instr(2, 0, 5, 1, 1, 1, 0, 0);
        bus.rd_label_i = 5'd0; bus.rd_data_i = 32'h12345678;
        step();
        check("x0_fwd", 64'(bus.rs1_value_o), 64'd0);
        check("rf_x5", 64'(bus.rs2_value_o), 64'hDEADBEEF);
        bus.rd_en_i = 0;
        step();
        check("x0_read", 64'(bus.rs1_value_o), 64'd0);

        // load-use: lw x3 then add x4,x3,x1
        set_instr(3, 2, 0, 1, 0, 1, 1, 0);
        step();
        check("lw_load", 64'(bus.is_load_o), 64'd1);
        check("lw_rd", 64'(bus.rd_o), 64'd3);
        set_instr(4, 3, 1, 1, 1, 1, 0, 0);
        #1 check("lu_stall", 64'(bus.stall_o), 64'd1);
        step();
        check("lu_bubble", 64'(bus.valid_o), 64'd0);
        check("lu_bub_ld", 64'(bus.is_load_o), 64'd0);
        check("lu_bub_ctrl", 64'(bus.ctrl_o), 64'd0);
        check("lu_cnt", 64'(bus.stall_cnt_o), 64'd1);
        check("lu_release", 64'(bus.stall_o), 64'd0);
        step();
        check("lu_add_valid", 64'(bus.valid_o), 64'd1);
        check("lu_add_rd", 64'(bus.rd_o), 64'd4);
        check("lu_cnt_hold", 64'(bus.stall_cnt_o), 64'd1);

        // long op x7 and a dependent add
        set_instr(7, 1, 2, 1, 1, 1, 0, 1);
        bus.pc_i = 31'h0000_0900;
        step();
        check("div_sb", 64'(bus.sb_busy_o), 64'h80);
        check("div_long", 64'(bus.is_long_o), 64'd1);
        set_instr(8, 7, 1, 1, 1, 1, 0, 0);
        bus.pc_i = 31'h0000_0A00;
        #1 check("sb_stall", 64'(bus.stall_o), 64'd1);
        step();
        check("sb_bubble", 64'(bus.valid_o), 64'd0);
        step();
        check("sb_cnt", 64'(bus.stall_cnt_o), 64'd3);

        // busywait during the stall: outputs and counter frozen
        bus.busywait_i = 1;
        repeat (3) step();
        check("bw_cnt", 64'(bus.stall_cnt_o), 64'd3);
        check("bw_pc", 64'(bus.pc_o), 64'h900);
        check("bw_valid", 64'(bus.valid_o), 64'd0);
        check("bw_sb", 64'(bus.sb_busy_o), 64'h80);
        bus.busywait_i = 0;

        // long writeback releases the stall in the same cycle
        bus.rd_en_i = 1; bus.rd_label_i = 5'd7; bus.rd_data_i = 32'h0BADF00D; bus.wb_long_i = 1;
        #1 check("wb_release", 64'(bus.stall_o), 64'd0);
        step();
        check("wb_rs1", 64'(bus.rs1_value_o), 64'h0BADF00D);
        check("wb_rd", 64'(bus.rd_o), 64'd8);
        check("wb_sb_clr", 64'(bus.sb_busy_o), 64'd0);
        check("wb_cnt", 64'(bus.stall_cnt_o), 64'd3);
        bus.rd_en_i = 0; bus.wb_long_i = 0;

        // busywait holds valid outputs
        set_instr(9, 1, 2, 1, 1, 1, 0, 0);
        bus.busywait_i = 1;
        step();
        check("bw_hold_rd", 64'(bus.rd_o), 64'd8);
        bus.busywait_i = 0;
        step();
        check("bw_release_rd", 64'(bus.rd_o), 64'd9);

        // flush with a pending hazard
        set_instr(10, 1, 2, 1, 1, 1, 0, 1);
        step();
        check("x10_sb", 64'(bus.sb_busy_o), 64'h400);
        set_instr(11, 10, 0, 1, 0, 1, 0, 1);
        bus.flush_i = 1;
        #1 check("flush_stall", 64'(bus.stall_o), 64'd0);
        step();
        check("flush_bubble", 64'(bus.valid_o), 64'd0);
        check("flush_sb", 64'(bus.sb_busy_o), 64'h400);
        bus.flush_i = 0;
        #1 check("post_flush_stall", 64'(bus.stall_o), 64'd1);
        step();
        check("cnt4", 64'(bus.stall_cnt_o), 64'd4);

        // long stall saturates the counter
        repeat (65536) step();
        check("cnt_sat", 64'(bus.stall_cnt_o), 64'hFFFF);
        check("sat_stall", 64'(bus.stall_o), 64'd1);

        // asynchronous reset mid-stall
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(bus.valid_o), 64'd0);
        check("ar_sb", 64'(bus.sb_busy_o), 64'd0);
        check("ar_cnt", 64'(bus.stall_cnt_o), 64'd0);
        check("ar_pc", 64'(bus.pc_o), 64'd0);
        check("ar_rd", 64'(bus.rd_o), 64'd0);
        check("ar_long", 64'(bus.is_long_o), 64'd0);
        #2 rst_n = 1'b1;
        set_instr(11, 10, 0, 1, 0, 1, 0, 0);
        bus.rd_en_i = 1; bus.rd_label_i = 5'd10; bus.rd_data_i = 32'h55; bus.wb_long_i = 1;
        #1 check("ar_no_stall", 64'(bus.stall_o), 64'd0);
        step();
        check("ar_sb_after", 64'(bus.sb_busy_o), 64'd0);
        check("ar_accept", 64'(bus.valid_o), 64'd1);
        check("ar_rs1", 64'(bus.rs1_value_o), 64'h55);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/id_scoreboard_stage.md
ID_SCOREBOARD_STAGE -- requirements
Module: id_scoreboard_stage

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width; NREGS, default 32, architectural register count (power of 2, AW = log2(NREGS)); CTRL_W, default 24, opaque decoded-control bundle width.
REQ-002 Ports SHALL be: clk_i in 1 clock; rst_i in 1 reset, asynchronous, active-low.
REQ-003 valid_i in 1 instruction present in ID; instr_i in 32 instruction word (rd=[11:7], rs1=[19:15], rs2=[24:20], low AW bits used); pc_i in XLEN-1 PC bits [XLEN-1:1]; imm_i in XLEN generated immediate; ctrl_i in CTRL_W control bundle.
REQ-004 uses_rs1_i in 1; uses_rs2_i in 1; reg_wen_i in 1 writes rd; is_load_i in 1; is_long_i in 1 multi-cycle result (mul/div/long load).
REQ-005 rd_en_i in 1 writeback enable; rd_label_i in AW; rd_data_i in XLEN; wb_long_i in 1 writeback completes a long op.
REQ-006 busywait_i in 1 memory hold; flush_i in 1 squash ID.
REQ-007 stall_o out 1; valid_o out 1; pc_o out XLEN-1; rs1_value_o, rs2_value_o, imm_o out XLEN; ctrl_o out CTRL_W; rd_o, rs1_o, rs2_o out AW; reg_wen_o, is_load_o, is_long_o out 1; sb_busy_o out NREGS pending-write bits; stall_cnt_o out 16 stall-cycle counter.

Function
REQ-008 Register file SHALL hold NREGS x XLEN, write on clk_i rising edge when rd_en_i and rd_label_i != 0; x0 SHALL read 0 always.
REQ-009 Reads SHALL be combinational with write-through: rsN equal to nonzero rd_label_i with rd_en_i returns rd_data_i same cycle.
REQ-010 clr_vec SHALL be one-hot of rd_label_i when rd_en_i and wb_long_i, else 0; effective scoreboard sb_eff = sb & ~clr_vec.
REQ-011 Scoreboard hazard: valid_i and ((uses_rs1_i and sb_eff[rs1]) or (uses_rs2_i and sb_eff[rs2]) or (reg_wen_i and sb_eff[rd])), rd/rs != 0.
REQ-012 Load-use hazard: valid_o and is_load_o and reg_wen_o and rd_o != 0 and ((uses_rs1_i and rs1==rd_o) or (uses_rs2_i and rs2==rd_o)).
REQ-013 stall_o SHALL be (scoreboard or load-use hazard) and not flush_i; combinational.
REQ-014 Accept = valid_i and not stall_o and not busywait_i and not flush_i.
REQ-015 ID/EX register priority per edge: busywait_i holds every output; else flush_i loads bubble; else stall_o loads bubble; else captures ID values with valid_o <= valid_i.
REQ-016 Bubble SHALL force valid_o, reg_wen_o, is_load_o, is_long_o to 0 and ctrl_o to 0; data fields don't-care (implementation holds them).
REQ-017 Scoreboard bit rd SHALL set on Accept with is_long_i, reg_wen_i, rd != 0; bits in clr_vec SHALL clear the same edge; set wins on same-register set/clear.
REQ-018 Bit 0 of scoreboard SHALL stay 0; sb_busy_o = registered scoreboard.
REQ-019 stall_cnt_o SHALL increment each cycle stall_o and not busywait_i, saturating at 16'hFFFF.
REQ-020 Latency: ID to ID/EX outputs one cycle; stall release the cycle after blocking bit clears or load leaves EX.

Reset
REQ-021 rst_i low SHALL asynchronously clear all registers, ID/EX outputs, scoreboard, stall_cnt_o and register file to 0; release is synchronous to next clk_i edge.
REQ-022 Reset mid-stall SHALL drop all pending scoreboard bits; no write-back after reset re-sets them.

Verification
REQ-023 Write x5=0xDEADBEEF via rd_en_i while ID reads rs1=x5 -> rs1_value_o=0xDEADBEEF next edge; write to x0 -> reads 0.
REQ-024 lw x3 accepted, next add x4,x3,x1 -> stall_o=1 one cycle, bubble valid_o=0, then add captured, stall_cnt_o=1.
REQ-025 div x7 (is_long_i) accepted -> sb_busy_o[7]=1; add using x7 stalls until rd_en_i,wb_long_i,rd_label_i=7, same cycle stall_o=0 and rs value = rd_data_i; sb_busy_o[7]=0 after.
REQ-026 busywait_i=1 for 3 cycles during stall -> outputs held, stall_cnt_o unchanged; flush_i with hazard -> stall_o=0, bubble, scoreboard not set.
REQ-027 Force stall 65540 cycles -> stall_cnt_o saturates at 0xFFFF; rst_i low mid-run -> all outputs 0 immediately, sb_busy_o=0.
